// File: rtl/rd_burst_fifo_if.sv
// Read-beat ingress and narrowed-lane egress bundle for rd_burst_fifo.
// The slave modport is the FIFO; the master modport is the read engine plus consumer.
interface rd_burst_fifo_if #(
    parameter int DEPTH_LOG2 = 6,
    parameter int OUT_W      = 32
);
    logic                  din_valid;
    logic                  din_ready;
    logic [63:0]           din;
    logic                  din_burst_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic [DEPTH_LOG2:0]   level;

    modport master (
        output din_valid, din, out_ready,
        input  din_ready, din_burst_ready, out_valid, out_data, level
    );

    modport slave (
        input  din_valid, din, out_ready,
        output din_ready, din_burst_ready, out_valid, out_data, level
    );
endinterface

// File: rtl/rd_burst_fifo.sv
// Elastic buffer behind the DRAM read engine: 64-bit beats into a block RAM,
// drained through a two-stage prefetch and split into OUT_W-bit lanes, LSB first.
module rd_burst_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int BURST_LEN  = 16,
    parameter int OUT_W      = 32
) (
    input  logic          fclk,
    input  logic          rst_n,
    input  logic          flush,
    rd_burst_fifo_if.slave bus
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int LEVEL_W = DEPTH_LOG2 + 1;
    localparam int LANES   = 64 / OUT_W;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LEVEL_W-1:0] DEPTH_FULL      = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0] BURST_MAX_LEVEL = LEVEL_W'(DEPTH - BURST_LEN);

    logic [63:0]           mem [DEPTH];
    logic [63:0]           ram_q_reg;
    logic [63:0]           hold_reg;
    logic                  ram_q_valid_reg;
    logic                  hold_valid_reg;
    logic                  burst_ready_reg;
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [LEVEL_W-1:0]    level_reg;
    logic [LEVEL_W-1:0]    level_next;
    logic [LEVEL_W-1:0]    mem_count;
    logic [LANE_W-1:0]     lane_reg;

    logic wr_en;
    logic rd_en;
    logic lane_take;
    logic last_lane;
    logic hold_free;
    logic q_to_hold;
    logic q_free;

    // level counts words not yet in the holding register, so the RAM output
    // register stays inside it; only words still in the array may be read.
    assign mem_count = level_reg - {{DEPTH_LOG2{1'b0}}, ram_q_valid_reg};

    assign lane_take = hold_valid_reg && bus.out_ready;
    assign last_lane = (lane_reg == LANE_W'(LANES - 1));
    assign hold_free = !hold_valid_reg || (lane_take && last_lane);
    assign q_to_hold = ram_q_valid_reg && hold_free && !flush;
    assign q_free    = !ram_q_valid_reg || q_to_hold;
    assign wr_en     = bus.din_valid && bus.din_ready && !flush;
    assign rd_en     = (mem_count != '0) && q_free && !flush;

    always_comb begin
        level_next = level_reg;
        if (flush) begin
            level_next = '0;
        end else if (wr_en && !q_to_hold) begin
            level_next = level_reg + 1'b1;
        end else if (!wr_en && q_to_hold) begin
            level_next = level_reg - 1'b1;
        end
    end

    // Storage and data path carry no reset so the array maps onto block RAM.
    always_ff @(posedge fclk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= bus.din;
        end
        if (rd_en) begin
            ram_q_reg <= mem[rd_ptr_reg];
        end
        if (q_to_hold) begin
            hold_reg <= ram_q_reg;
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            lane_reg        <= '0;
            ram_q_valid_reg <= 1'b0;
            hold_valid_reg  <= 1'b0;
            burst_ready_reg <= 1'b0;
        end else begin
            level_reg       <= level_next;
            burst_ready_reg <= (level_next <= BURST_MAX_LEVEL);
            if (flush) begin
                wr_ptr_reg      <= '0;
                rd_ptr_reg      <= '0;
                lane_reg        <= '0;
                ram_q_valid_reg <= 1'b0;
                hold_valid_reg  <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (rd_en) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                if (rd_en) begin
                    ram_q_valid_reg <= 1'b1;
                end else if (q_to_hold) begin
                    ram_q_valid_reg <= 1'b0;
                end
                if (q_to_hold) begin
                    hold_valid_reg <= 1'b1;
                end else if (lane_take && last_lane) begin
                    hold_valid_reg <= 1'b0;
                end
                if (lane_take) begin
                    lane_reg <= last_lane ? '0 : lane_reg + 1'b1;
                end
            end
        end
    end

    logic [OUT_W-1:0] lane_data [LANES];
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_data[gi] = hold_reg[gi*OUT_W +: OUT_W];
    end

    assign bus.out_data        = lane_data[lane_reg];
    assign bus.out_valid       = hold_valid_reg;
    assign bus.din_ready       = (level_reg != DEPTH_FULL);
    assign bus.din_burst_ready = burst_ready_reg;
    assign bus.level           = level_reg;
endmodule

// File: tb/tb_rd_burst_fifo.sv
// Scenario bench for rd_burst_fifo: FIFO ordering, occupancy, burst credit, flush and async reset,
// each output lane checked against a queue of lanes derived from the beats that were sent.
`timescale 1ns/1ps
module tb_rd_burst_fifo;
    localparam int DEPTH_LOG2 = 6;
    localparam int BURST_LEN  = 16;
    localparam int OUT_W      = 32;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int LANES      = 64 / OUT_W;

    logic fclk  = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    rd_burst_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2), .OUT_W(OUT_W)) bus ();

    rd_burst_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .BURST_LEN(BURST_LEN), .OUT_W(OUT_W)) dut (
        .fclk  (fclk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 fclk = ~fclk;

    int checks = 0;
    int passed = 0;
    logic [OUT_W-1:0] got[$];
    logic [OUT_W-1:0] exp_q[$];
    int accepted = 0;

    // Observe handshakes mid-cycle, where inputs and outputs are both settled.
    always @(negedge fclk) begin
        if (rst_n && !flush) begin
            if (bus.din_valid && bus.din_ready) accepted++;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge fclk);
            #1;
        end
    endtask

    task automatic push_word(input logic [63:0] w);
        for (int l = 0; l < LANES; l++) exp_q.push_back(w[l*OUT_W +: OUT_W]);
    endtask

    task automatic clear_sb();
        got.delete();
        exp_q.delete();
        accepted = 0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_sb();
    endtask

    task automatic drain(input int n_lanes, input int limit, output bit ok);
        int c = 0;
        while (got.size() < n_lanes && c < limit) begin
            tick();
            c++;
        end
        ok = (got.size() >= n_lanes);
        tick(6);
    endtask

    function automatic int first_diff();
        int n = (got.size() > exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= got.size() || i >= exp_q.size()) return i;
            if (got[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        bit [DEPTH_LOG2:0] lv;
        rst_n = 1'b0;
        #23;
        lv = bus.level;
        checks++; if (lv !== 0) $display("FAIL reset_level: got %0d want 0", lv); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.din_burst_ready !== 1'b0) $display("FAIL reset_burst_ready: got %b want 0", bus.din_burst_ready); else passed++;
        @(posedge fclk);
        #3 rst_n = 1'b1;
        tick();
        checks++; if (bus.din_burst_ready !== 1'b1) $display("FAIL release_burst_ready: got %b want 1", bus.din_burst_ready); else passed++;
        checks++; if (bus.din_ready !== 1'b1) $display("FAIL release_din_ready: got %b want 1", bus.din_ready); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL release_out_valid: got %b want 0", bus.out_valid); else passed++;
        $display("reset: released, level=%0d burst_ready=%b", bus.level, bus.din_burst_ready);
    endtask

    task automatic test_basic();
        logic [63:0] w;
        bit ok;
        int d;
        clear_sb();
        bus.out_ready = 1'b0;
        w = 64'h0000_0001_0000_0000;
        bus.din = w; bus.din_valid = 1'b1;
        push_word(w);
        tick();
        bus.din_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL latency_edge1: out_valid got %b want 0", bus.out_valid); else passed++;
        tick();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL latency_edge2: out_valid got %b want 0", bus.out_valid); else passed++;
        tick();
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL latency_edge3: out_valid got %b want 1", bus.out_valid); else passed++;
        checks++; if (bus.out_data !== exp_q[0]) $display("FAIL first_lane: got %h want %h", bus.out_data, exp_q[0]); else passed++;
        bus.out_ready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            w = 64'h0000_0001_0000_0000 + 64'(k);
            bus.din = w; bus.din_valid = 1'b1;
            push_word(w);
            tick();
        end
        bus.din_valid = 1'b0;
        drain(32, 200, ok);
        checks++; if (!ok) $display("FAIL basic_timeout: got %0d lanes want 32", got.size()); else passed++;
        d = first_diff();
        checks++;
        if (d != -1) $display("FAIL basic_order: lane %0d got %h want %h (lanes got %0d want %0d)", d,
                              (d < got.size()) ? got[d] : '0, (d < exp_q.size()) ? exp_q[d] : '0, got.size(), exp_q.size());
        else passed++;
        checks++; if (bus.level !== 0) $display("FAIL basic_level_end: got %0d want 0", bus.level); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_valid_end: got %b want 0", bus.out_valid); else passed++;
        $display("basic: 16 beats sent, %0d lanes received", got.size());
    endtask

    task automatic test_burst_ready();
        int exp_lvl;
        bit exp_br;
        do_flush();
        bus.out_ready = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            bus.din = {$urandom, $urandom}; bus.din_valid = 1'b1;
            tick();
            bus.din_valid = 1'b0;
            tick(3);
            exp_lvl = n - 1;
            exp_br  = (DEPTH - exp_lvl) >= BURST_LEN;
            checks++; if (bus.level !== exp_lvl) $display("FAIL burst_level n=%0d: got %0d want %0d", n, bus.level, exp_lvl); else passed++;
            checks++; if (bus.din_burst_ready !== exp_br) $display("FAIL burst_ready n=%0d: got %b want %b", n, bus.din_burst_ready, exp_br); else passed++;
            $display("burst: write %0d level=%0d burst_ready=%b", n, bus.level, bus.din_burst_ready);
        end
    endtask

    task automatic test_full();
        logic [63:0] words [66];
        bit ok;
        int d;
        do_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 66; i++) begin
            words[i] = {$urandom, $urandom};
            bus.din = words[i]; bus.din_valid = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
        tick(3);
        checks++; if (bus.level !== DEPTH) $display("FAIL full_level: got %0d want %0d", bus.level, DEPTH); else passed++;
        checks++; if (bus.din_ready !== 1'b0) $display("FAIL full_din_ready: got %b want 0", bus.din_ready); else passed++;
        checks++; if (bus.din_burst_ready !== 1'b0) $display("FAIL full_burst_ready: got %b want 0", bus.din_burst_ready); else passed++;
        checks++; if (accepted != DEPTH + 1) $display("FAIL full_accepted: got %0d want %0d", accepted, DEPTH + 1); else passed++;
        for (int i = 0; i < DEPTH + 1; i++) push_word(words[i]);
        bus.out_ready = 1'b1;
        drain(2 * (DEPTH + 1), 400, ok);
        checks++; if (!ok) $display("FAIL full_timeout: got %0d lanes want %0d", got.size(), 2 * (DEPTH + 1)); else passed++;
        d = first_diff();
        checks++;
        if (d != -1) $display("FAIL full_order: lane %0d got %h want %h (lanes got %0d want %0d)", d,
                              (d < got.size()) ? got[d] : '0, (d < exp_q.size()) ? exp_q[d] : '0, got.size(), exp_q.size());
        else passed++;
        checks++; if (bus.level !== 0) $display("FAIL full_level_end: got %0d want 0", bus.level); else passed++;
        $display("full: %0d beats accepted, %0d lanes received", accepted, got.size());
    endtask

    task automatic test_stream();
        int lv [100];
        bit seen;
        int drops;
        int bad_rate;
        bit ok;
        int d;
        logic [63:0] w;
        do_flush();
        seen = 0; drops = 0; bad_rate = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            w = {$urandom, $urandom};
            bus.din = w; bus.din_valid = 1'b1;
            push_word(w);
            tick();
            lv[c] = int'(bus.level);
            if (bus.out_valid) seen = 1;
            else if (seen) drops++;
        end
        bus.din_valid = 1'b0;
        for (int c = 10; c < 98; c++) if (lv[c+2] - lv[c] != 1) bad_rate++;
        checks++; if (!seen || drops != 0) $display("FAIL stream_valid: seen %b drops %0d want seen 1 drops 0", seen, drops); else passed++;
        checks++; if (bad_rate != 0) $display("FAIL stream_rate: %0d windows off, level %0d at cycle 98 want 1 per 2 cycles", bad_rate, lv[98]); else passed++;
        checks++; if (accepted != 100) $display("FAIL stream_accepted: got %0d want 100", accepted); else passed++;
        drain(200, 400, ok);
        checks++; if (!ok) $display("FAIL stream_timeout: got %0d lanes want 200", got.size()); else passed++;
        d = first_diff();
        checks++;
        if (d != -1) $display("FAIL stream_order: lane %0d got %h want %h (lanes got %0d want %0d)", d,
                              (d < got.size()) ? got[d] : '0, (d < exp_q.size()) ? exp_q[d] : '0, got.size(), exp_q.size());
        else passed++;
        $display("stream: 100 beats, level after 100 cycles=%0d, %0d lanes received", lv[99], got.size());
    endtask

    task automatic test_flush();
        logic [63:0] w;
        bit ok;
        int d;
        do_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 21; i++) begin
            bus.din = {$urandom, $urandom}; bus.din_valid = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
        tick(3);
        checks++; if (bus.level !== 20) $display("FAIL flush_pre_level: got %0d want 20", bus.level); else passed++;
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL flush_pre_valid: got %b want 1", bus.out_valid); else passed++;
        flush = 1'b1; bus.din_valid = 1'b1; bus.din = {$urandom, $urandom}; bus.out_ready = 1'b1;
        tick();
        flush = 1'b0; bus.din_valid = 1'b0; bus.out_ready = 1'b0;
        checks++; if (bus.level !== 0) $display("FAIL flush_level: got %0d want 0", bus.level); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.din_burst_ready !== 1'b1) $display("FAIL flush_burst_ready: got %b want 1", bus.din_burst_ready); else passed++;
        clear_sb();
        w = {$urandom, $urandom};
        bus.din = w; bus.din_valid = 1'b1;
        push_word(w);
        tick();
        bus.din_valid = 1'b0; bus.out_ready = 1'b1;
        drain(LANES, 50, ok);
        checks++; if (!ok) $display("FAIL flush_timeout: got %0d lanes want %0d", got.size(), LANES); else passed++;
        d = first_diff();
        checks++;
        if (d != -1) $display("FAIL flush_next_write: lane %0d got %h want %h (lanes got %0d want %0d)", d,
                              (d < got.size()) ? got[d] : '0, (d < exp_q.size()) ? exp_q[d] : '0, got.size(), exp_q.size());
        else passed++;
        $display("flush: post-flush word %h, %0d lanes received", w, got.size());
    endtask

    task automatic test_reset_mid();
        logic [63:0] w;
        bit ok;
        int d;
        clear_sb();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.din = {$urandom, $urandom}; bus.din_valid = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #2;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL async_out_valid: got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.level !== 0) $display("FAIL async_level: got %0d want 0", bus.level); else passed++;
        checks++; if (bus.din_burst_ready !== 1'b0) $display("FAIL async_burst_ready: got %b want 0", bus.din_burst_ready); else passed++;
        bus.din_valid = 1'b0;
        @(posedge fclk);
        #3 rst_n = 1'b1;
        tick();
        checks++; if (bus.din_burst_ready !== 1'b1) $display("FAIL mid_release_burst: got %b want 1", bus.din_burst_ready); else passed++;
        clear_sb();
        w = {$urandom, $urandom};
        bus.din = w; bus.din_valid = 1'b1;
        push_word(w);
        tick();
        bus.din_valid = 1'b0;
        drain(LANES, 50, ok);
        checks++; if (!ok) $display("FAIL mid_timeout: got %0d lanes want %0d", got.size(), LANES); else passed++;
        d = first_diff();
        checks++;
        if (d != -1) $display("FAIL mid_fresh_data: lane %0d got %h want %h (lanes got %0d want %0d)", d,
                              (d < got.size()) ? got[d] : '0, (d < exp_q.size()) ? exp_q[d] : '0, got.size(), exp_q.size());
        else passed++;
        $display("reset_mid: fresh word %h, %0d lanes received", w, got.size());
    endtask

    task automatic test_random();
        localparam int N = 60;
        logic [63:0] words [N];
        int idx;
        int cyc;
        bit acc;
        int d;
        do_flush();
        for (int i = 0; i < N; i++) begin
            words[i] = {$urandom, $urandom};
            push_word(words[i]);
        end
        idx = 0; cyc = 0;
        while ((idx < N || got.size() < 2 * N) && cyc < 3000) begin
            bus.din_valid = (idx < N) && ($urandom_range(0, 1) == 1);
            if (idx < N) bus.din = words[idx];
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge fclk);
            acc = bus.din_valid && bus.din_ready;
            @(posedge fclk);
            #1;
            if (acc) begin
                $display("random: beat %0d accepted at cycle %0d", idx, cyc);
                idx++;
            end
            cyc++;
        end
        bus.din_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick(6);
        checks++; if (cyc >= 3000) $display("FAIL random_timeout: sent %0d of %0d, lanes %0d", idx, N, got.size()); else passed++;
        d = first_diff();
        checks++;
        if (d != -1) $display("FAIL random_order: lane %0d got %h want %h (lanes got %0d want %0d)", d,
                              (d < got.size()) ? got[d] : '0, (d < exp_q.size()) ? exp_q[d] : '0, got.size(), exp_q.size());
        else passed++;
        checks++; if (bus.level !== 0) $display("FAIL random_level_end: got %0d want 0", bus.level); else passed++;
    endtask

    initial begin
        bus.din_valid = 1'b0;
        bus.din       = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_burst_ready();
        test_full();
        test_stream();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
